// File: rtl/lcd_nibble_sequencer.sv
// lcd_nibble_sequencer: feeds the LCD base driver. Runs the HD44780 4-bit
// power-on init (nibbles 3,3,3,2), then sends bytes as two nibbles. Each
// nibble steps the phase counter 0..3, and the controller's execution waits
// are enforced between nibbles.
//
// Request handshake: a byte transfers on a rising clk edge where
// req_valid & req_ready are both high. req_ready is high only in IDLE, so at
// most one byte is in flight. req_rs/req_long/req_data are sampled only on
// that cycle. A request that arrives while the sequencer is busy is held off,
// not dropped.
module lcd_nibble_sequencer #(
    parameter int PHASE_CYCLES = 12,
    parameter int POWERON_WAIT = 750000,
    parameter int INIT_WAIT1   = 205000,
    parameter int INIT_WAIT2   = 5000,
    parameter int NIBBLE_GAP   = 50,
    parameter int CMD_WAIT     = 2000,
    parameter int LONG_WAIT    = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic       req_long,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       rs_signal,
    output logic [3:0] data_out,
    output logic [1:0] counter,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, HI_NIB, GAP, LO_NIB, POST_WAIT
    } state_t;

    // The timer is loaded with N-1 on entry, so a wait of N holds the state
    // for exactly N clocks.
    localparam logic [19:0] T_PHASE = 20'(PHASE_CYCLES - 1);
    localparam logic [19:0] T_PWR   = 20'(POWERON_WAIT - 1);
    localparam logic [19:0] T_INIT1 = 20'(INIT_WAIT1 - 1);
    localparam logic [19:0] T_INIT2 = 20'(INIT_WAIT2 - 1);
    localparam logic [19:0] T_GAP   = 20'(NIBBLE_GAP - 1);
    localparam logic [19:0] T_CMD   = 20'(CMD_WAIT - 1);
    localparam logic [19:0] T_LONG  = 20'(LONG_WAIT - 1);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [3:0]  lo_q, lo_d;
    logic        long_q, long_d;
    logic [3:0]  nib_q, nib_d;
    logic        rs_q, rs_d;
    logic        timer_zero;

    assign timer_zero = (timer_q == 20'd0);

    // State register: every piece of sequencer state, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PWR_WAIT;
            timer_q <= T_PWR;
            phase_q <= 2'd0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            lo_q    <= 4'd0;
            long_q  <= 1'b0;
            nib_q   <= 4'd0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            lo_q    <= lo_d;
            long_q  <= long_d;
            nib_q   <= nib_d;
            rs_q    <= rs_d;
        end
    end

    // Next-state logic: timer countdown, phase stepping and state transitions.
    always_comb begin
        state_d = state_q;
        timer_d = timer_zero ? timer_q : timer_q - 20'd1;
        phase_d = phase_q;
        idx_d   = idx_q;
        done_d  = done_q;
        lo_d    = lo_q;
        long_d  = long_q;
        nib_d   = nib_q;
        rs_d    = rs_q;
        case (state_q)
            PWR_WAIT: begin
                if (timer_zero) begin
                    state_d = INIT_NIB;
                    timer_d = T_PHASE;
                    phase_d = 2'd0;
                    nib_d   = 4'h3;
                    rs_d    = 1'b0;
                end
            end
            INIT_NIB, HI_NIB, LO_NIB: begin
                if (timer_zero) begin
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                        timer_d = T_PHASE;
                    end else begin
                        phase_d = 2'd0;
                        if (state_q == INIT_NIB) begin
                            state_d = INIT_WAIT;
                            case (idx_q)
                                2'd0:    timer_d = T_INIT1;
                                2'd1:    timer_d = T_INIT2;
                                default: timer_d = T_CMD;
                            endcase
                        end else if (state_q == HI_NIB) begin
                            state_d = GAP;
                            timer_d = T_GAP;
                        end else begin
                            state_d = POST_WAIT;
                            timer_d = long_q ? T_LONG : T_CMD;
                        end
                    end
                end
            end
            INIT_WAIT: begin
                if (timer_zero) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_NIB;
                        timer_d = T_PHASE;
                        phase_d = 2'd0;
                        // The last init nibble (index 3) is 2, the rest are 3.
                        nib_d   = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                        rs_d    = 1'b0;
                    end
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_d = HI_NIB;
                    timer_d = T_PHASE;
                    phase_d = 2'd0;
                    nib_d   = req_data[7:4];
                    lo_d    = req_data[3:0];
                    rs_d    = req_rs;
                    long_d  = req_long;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    state_d = LO_NIB;
                    timer_d = T_PHASE;
                    phase_d = 2'd0;
                    nib_d   = lo_q;
                end
            end
            POST_WAIT: begin
                if (timer_zero) state_d = IDLE;
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    // Outputs: the phase is shown only inside a nibble window, so E pulses
    // exactly once per nibble. Nibble and RS are held between updates.
    always_comb begin
        counter   = 2'd0;
        if (state_q == INIT_NIB || state_q == HI_NIB || state_q == LO_NIB)
            counter = phase_q;
        req_ready = (state_q == IDLE);
        init_done = done_q;
        data_out  = nib_q;
        rs_signal = rs_q;
        fsm_state = state_q;
    end

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Testbench for lcd_nibble_sequencer with reduced timing parameters.
// Expected nibbles are queued when a byte (or the init sequence) is started
// and popped when the DUT raises the E phase; waits are timed by counting
// clocks of counter==0 between nibbles.
module tb_lcd_nibble_sequencer;

  localparam int PC   = 2;
  localparam int PWR  = 20;
  localparam int IW1  = 10;
  localparam int IW2  = 6;
  localparam int GAPC = 3;
  localparam int CMD  = 5;
  localparam int LONG = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_long = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       rs_signal;
  logic [3:0] data_out;
  logic [1:0] counter;
  logic [2:0] fsm_state;

  int         n_checks = 0;
  int         n_pass = 0;
  int         e_cnt = 0;
  logic [1:0] prev_cnt = 2'd0;
  logic [4:0] last_nib = 5'd0;
  logic [4:0] exp_q[$];

  lcd_nibble_sequencer #(
    .PHASE_CYCLES(PC), .POWERON_WAIT(PWR), .INIT_WAIT1(IW1), .INIT_WAIT2(IW2),
    .NIBBLE_GAP(GAPC), .CMD_WAIT(CMD), .LONG_WAIT(LONG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
    .req_long(req_long), .req_data(req_data), .req_ready(req_ready),
    .init_done(init_done), .rs_signal(rs_signal), .data_out(data_out),
    .counter(counter), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Advance to the next falling edge and run the scoreboard on the outputs.
  task automatic tick();
    logic [1:0] step;
    logic [4:0] want;
    @(negedge clk);
    if (rst_n && counter != prev_cnt) begin
      step = prev_cnt + 2'd1;
      check("cnt_step", 32'(counter), 32'(step));
    end
    if (counter == 2'd2) e_cnt++;
    if (counter == 2'd2 && prev_cnt != 2'd2) begin
      if (exp_q.size() == 0) begin
        check("nib_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        want = exp_q.pop_front();
        check("nibble", 32'({rs_signal, data_out}), 32'(want));
      end
      last_nib = {rs_signal, data_out};
    end
    if (rst_n && counter == 2'd3 && prev_cnt == 2'd2)
      check("nib_hold", 32'({rs_signal, data_out}), 32'(last_nib));
    prev_cnt = counter;
  endtask

  // Count clocks with counter==0 starting at the current sample.
  task automatic zero_run(input string tag, input int want);
    int n;
    n = 0;
    while (counter == 2'd0 && n < 200) begin
      n++;
      tick();
    end
    check(tag, 32'(n), 32'(want));
  endtask

  // Phases 1..3 must each last PC clocks.
  task automatic check_nibble(input string tag);
    for (int ph = 1; ph <= 3; ph++) begin
      int n;
      n = 0;
      while (counter == 2'(ph) && n < 50) begin
        n++;
        tick();
      end
      check(tag, 32'(n), 32'(PC));
    end
  endtask

  // Starting at the first clock of a wait of w clocks, end at the first IDLE clock.
  task automatic post_wait(input string tag, input int w);
    repeat (w - 1) tick();
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
  endtask

  // Called on the clock rst_n is released; ends on the first IDLE clock.
  task automatic run_init(input string tag);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    zero_run({tag, "_pwr"}, PWR + PC);
    check_nibble({tag, "_n0"});
    zero_run({tag, "_w1"}, IW1 + PC);
    check_nibble({tag, "_n1"});
    zero_run({tag, "_w2"}, IW2 + PC);
    check_nibble({tag, "_n2"});
    zero_run({tag, "_w3"}, CMD + PC);
    check_nibble({tag, "_n3"});
    check({tag, "_not_done"}, 32'(init_done), 32'd0);
    post_wait(tag, CMD);
    check({tag, "_done"}, 32'(init_done), 32'd1);
  endtask

  // From the first HI_NIB clock of an accepted byte to the next IDLE clock.
  task automatic byte_flow(input string tag, input int w);
    zero_run({tag, "_ph0"}, PC);
    check_nibble({tag, "_hi"});
    zero_run({tag, "_gap"}, GAPC + PC);
    check_nibble({tag, "_lo"});
    post_wait(tag, w);
  endtask

  // Present a byte on an IDLE clock; it is accepted on the next edge.
  task automatic send_byte(input string tag, input logic rs, input logic lng,
                           input logic [7:0] d, input int w);
    req_valid = 1'b1;
    req_rs    = rs;
    req_long  = lng;
    req_data  = d;
    push_byte(rs, d);
    tick();
    check({tag, "_accept"}, 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    req_rs    = ~rs;
    req_long  = ~lng;
    req_data  = ~d;
    byte_flow(tag, w);
  endtask

  initial begin
    int e_base;
    int n;
    repeat (3) tick();
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_rs", 32'(rs_signal), 32'd0);
    rst_n = 1'b1;
    run_init("init");

    send_byte("b48", 1'b1, 1'b0, 8'h48, CMD);

    e_base = e_cnt;
    send_byte("b01", 1'b0, 1'b1, 8'h01, LONG);
    check("b01_e_cycles", 32'(e_cnt - e_base), 32'(2 * PC));

    // Reset during phase 2 of the lower nibble.
    req_valid = 1'b1;
    req_rs    = 1'b0;
    req_long  = 1'b0;
    req_data  = 8'hA5;
    push_byte(1'b0, 8'hA5);
    tick();
    req_valid = 1'b0;
    zero_run("ba5_ph0", PC);
    check_nibble("ba5_hi");
    zero_run("ba5_gap", GAPC + PC);
    n = 0;
    while (counter != 2'd2 && n < 20) begin
      n++;
      tick();
    end
    check("ba5_lo_e", 32'(counter), 32'd2);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h3C;
    tick();
    check("abort_counter", 32'(counter), 32'd0);
    check("abort_done", 32'(init_done), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_init("reinit");
    push_byte(1'b1, 8'h3C);

    // req_valid was held through init: accepted on the first IDLE clock.
    tick();
    check("b3c_accept", 32'(req_ready), 32'd0);
    req_rs   = 1'b0;
    req_long = 1'b1;
    req_data = 8'h77;
    push_byte(1'b0, 8'h77);
    byte_flow("b3c", CMD);
    tick();
    check("b77_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    req_data  = 8'h00;
    byte_flow("b77", LONG);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
